dna_tile_renderer: RTL

- Pixel-generation stage directly downstream of the VGA sync module.
- Consumes the sync module's X/Y/valid/HS/VS and produces aligned RGB plus delayed syncs for the DAC.
- Screen is a grid of 16x16-pixel tiles, each showing one DNA base as a colour, with optional match highlighting.
- Tile contents come from an internal dual-port tile RAM written by the upstream sequence-mapping logic; a post-reset clear sequencer zeroes the RAM.

---
 rtl/dna_tile_renderer_pkg.sv | 37 +++
 rtl/dna_tile_renderer_tile_ram.sv | 34 +++
 rtl/dna_tile_renderer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/dna_tile_renderer_pkg.sv
// Shared constants for the DNA tile renderer: tile geometry, base codes and colour masks.
// Colour masks are {red, green, blue} channel enables; intensity is applied in the renderer.
package dna_tile_renderer_pkg;

    localparam int TILE_LOG2 = 4;
    localparam int COLS      = 40;
    localparam int ROWS      = 30;

    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_C = 2'b01;
    localparam logic [1:0] BASE_G = 2'b10;
    localparam logic [1:0] BASE_T = 2'b11;

    localparam logic [2:0] COL_A    = 3'b010;
    localparam logic [2:0] COL_C    = 3'b001;
    localparam logic [2:0] COL_G    = 3'b110;
    localparam logic [2:0] COL_T    = 3'b100;
    localparam logic [2:0] COL_GRID = 3'b111;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ctrl_state_t;

    function automatic logic [2:0] base_rgb_mask(input logic [1:0] base);
        logic [2:0] mask;
        case (base)
            BASE_A:  mask = COL_A;
            BASE_C:  mask = COL_C;
            BASE_G:  mask = COL_G;
            BASE_T:  mask = COL_T;
            default: mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dna_tile_renderer_tile_ram.sv
// Simple dual-port tile store: one write port, one registered read port.
// A same-address read/write returns the old contents (read-before-write).
module tile_ram #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];

    // Write port; the array itself has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port with a synchronous output-register reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= {DATA_W{1'b0}};
        end else begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/dna_tile_renderer.sv
// Three-stage pixel generator: tile lookup, RAM read, colour mapping; syncs delayed to match.
// A post-reset clear sequencer zeroes the tile RAM before upstream writes are accepted.
module dna_tile_renderer #(
    parameter int P_WIDTH   = 11,
    parameter int TILE_LOG2 = dna_tile_renderer_pkg::TILE_LOG2,
    parameter int COLS      = dna_tile_renderer_pkg::COLS,
    parameter int ROWS      = dna_tile_renderer_pkg::ROWS,
    parameter int ADDR_W    = 11,
    parameter int COLOR_W   = 8
) (
    input  logic               VGA_CLK,
    input  logic               VGA_RST,
    input  logic               VALID_IN,
    input  logic [P_WIDTH-1:0] X_IN,
    input  logic [P_WIDTH-1:0] Y_IN,
    input  logic               HS_IN,
    input  logic               VS_IN,
    input  logic               WR_EN,
    input  logic [ADDR_W-1:0]  WR_ADDR,
    input  logic [2:0]         WR_DATA,
    output logic               WR_READY,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK_N,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B
);

    import dna_tile_renderer_pkg::*;

    localparam logic [ADDR_W-1:0]  LAST_TILE = ADDR_W'(COLS * ROWS - 1);
    localparam logic [P_WIDTH-1:0] COLS_LIM  = P_WIDTH'(COLS);
    localparam logic [P_WIDTH-1:0] ROWS_LIM  = P_WIDTH'(ROWS);
    localparam logic [COLOR_W-1:0] FULL      = {COLOR_W{1'b1}};
    localparam logic [COLOR_W-1:0] HALF      = {1'b0, {(COLOR_W-1){1'b1}}};
    localparam logic [COLOR_W-1:0] GREY      = {2'b01, {(COLOR_W-2){1'b0}}};

    ctrl_state_t         state_r;
    logic [ADDR_W-1:0]   clr_cnt_r;

    logic                ram_we_s;
    logic [ADDR_W-1:0]   ram_waddr_s;
    logic [2:0]          ram_wdata_s;
    logic [2:0]          ram_q_s;

    logic [P_WIDTH-1:0]  col_s;
    logic [P_WIDTH-1:0]  row_s;
    logic [ADDR_W-1:0]   rd_addr_s;

    logic [ADDR_W-1:0]   rd_addr_r;
    logic                s1_in_grid_r, s1_edge_r, s1_valid_r, s1_hs_r, s1_vs_r;
    logic                s2_in_grid_r, s2_edge_r, s2_valid_r, s2_hs_r, s2_vs_r;
    logic                s2_clear_r;

    logic [2:0]          mask_s;
    logic [COLOR_W-1:0]  lvl_s;
    logic [COLOR_W-1:0]  r_s, g_s, b_s;

    // Controller: CLEAR walks every tile address once, then RUN accepts upstream writes.
    always_ff @(posedge VGA_CLK) begin
        if (VGA_RST) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= {ADDR_W{1'b0}};
            WR_READY  <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clr_cnt_r <= clr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (clr_cnt_r == LAST_TILE) begin
                        state_r  <= ST_RUN;
                        WR_READY <= 1'b1;
                    end else begin
                        state_r  <= ST_CLEAR;
                        WR_READY <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state_r  <= ST_RUN;
                    WR_READY <= 1'b1;
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_cnt_r <= {ADDR_W{1'b0}};
                    WR_READY  <= 1'b0;
                end
            endcase
        end
    end

    // Write-port mux: the clear sequencer owns the port until RUN; out-of-range writes drop.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = WR_ADDR;
        ram_wdata_s = WR_DATA;
        case (state_r)
            ST_CLEAR: begin
                ram_we_s    = 1'b1;
                ram_waddr_s = clr_cnt_r;
                ram_wdata_s = 3'b000;
            end
            ST_RUN: begin
                ram_we_s = WR_EN && (WR_ADDR <= LAST_TILE);
            end
            default: begin
                ram_we_s = 1'b0;
            end
        endcase
    end

    tile_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (3)
    ) u_tile_ram (
        .clk     (VGA_CLK),
        .rst     (VGA_RST),
        .we      (ram_we_s),
        .wr_addr (ram_waddr_s),
        .wr_data (ram_wdata_s),
        .rd_addr (rd_addr_r),
        .rd_data (ram_q_s)
    );

    // Tile coordinates; the linear index wraps modulo 2^ADDR_W, off-grid pixels are masked later.
    always_comb begin
        col_s     = X_IN >> TILE_LOG2;
        row_s     = Y_IN >> TILE_LOG2;
        rd_addr_s = ADDR_W'(row_s) * ADDR_W'(COLS) + ADDR_W'(col_s);
    end

    // S1 and S2 pipeline registers; sync stages idle high, everything else idles low.
    always_ff @(posedge VGA_CLK) begin
        if (VGA_RST) begin
            rd_addr_r    <= {ADDR_W{1'b0}};
            s1_in_grid_r <= 1'b0;
            s1_edge_r    <= 1'b0;
            s1_valid_r   <= 1'b0;
            s1_hs_r      <= 1'b1;
            s1_vs_r      <= 1'b1;
            s2_in_grid_r <= 1'b0;
            s2_edge_r    <= 1'b0;
            s2_valid_r   <= 1'b0;
            s2_hs_r      <= 1'b1;
            s2_vs_r      <= 1'b1;
            s2_clear_r   <= 1'b0;
        end else begin
            rd_addr_r    <= rd_addr_s;
            s1_in_grid_r <= (col_s < COLS_LIM) && (row_s < ROWS_LIM);
            s1_edge_r    <= (X_IN[TILE_LOG2-1:0] == {TILE_LOG2{1'b0}}) ||
                            (Y_IN[TILE_LOG2-1:0] == {TILE_LOG2{1'b0}});
            s1_valid_r   <= VALID_IN;
            s1_hs_r      <= HS_IN;
            s1_vs_r      <= VS_IN;
            s2_in_grid_r <= s1_in_grid_r;
            s2_edge_r    <= s1_edge_r;
            s2_valid_r   <= s1_valid_r;
            s2_hs_r      <= s1_hs_r;
            s2_vs_r      <= s1_vs_r;
            s2_clear_r   <= (state_r == ST_CLEAR);
        end
    end

    // S3 colour rule: blank/clear/off-grid black, tile edges grey, else base colour at full or half.
    always_comb begin
        mask_s = base_rgb_mask(ram_q_s[1:0]);
        lvl_s  = ram_q_s[2] ? FULL : HALF;
        r_s    = {COLOR_W{1'b0}};
        g_s    = {COLOR_W{1'b0}};
        b_s    = {COLOR_W{1'b0}};
        if (!s2_valid_r || s2_clear_r || !s2_in_grid_r) begin
            r_s = {COLOR_W{1'b0}};
            g_s = {COLOR_W{1'b0}};
            b_s = {COLOR_W{1'b0}};
        end else if (s2_edge_r) begin
            r_s = COL_GRID[2] ? GREY : {COLOR_W{1'b0}};
            g_s = COL_GRID[1] ? GREY : {COLOR_W{1'b0}};
            b_s = COL_GRID[0] ? GREY : {COLOR_W{1'b0}};
        end else begin
            r_s = mask_s[2] ? lvl_s : {COLOR_W{1'b0}};
            g_s = mask_s[1] ? lvl_s : {COLOR_W{1'b0}};
            b_s = mask_s[0] ? lvl_s : {COLOR_W{1'b0}};
        end
    end

    // S3 output registers feeding the DAC.
    always_ff @(posedge VGA_CLK) begin
        if (VGA_RST) begin
            VGA_R       <= {COLOR_W{1'b0}};
            VGA_G       <= {COLOR_W{1'b0}};
            VGA_B       <= {COLOR_W{1'b0}};
            VGA_BLANK_N <= 1'b0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
        end else begin
            VGA_R       <= r_s;
            VGA_G       <= g_s;
            VGA_B       <= b_s;
            VGA_BLANK_N <= s2_valid_r;
            VGA_HS      <= s2_hs_r;
            VGA_VS      <= s2_vs_r;
        end
    end

endmodule
